rib_rr_bus: RTL and testbench

//  Parametrised RIB bus, next generation of the fixed 4x8 RIB. N masters share one slave path.

---
 rtl/rib_rr_bus_pkg.sv | 19 +
 rtl/rib_rr_arbiter.sv | 32 +++
 rtl/rib_rr_bus.sv | 137 +++++++++++++
 tb/tb_rib_rr_bus.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rib_rr_bus_pkg.sv
// Shared FSM encoding and timer sizing helper for the RIB round-robin bus.
// No logic; imported by the bus top and its arbiter.
package rib_rr_bus_pkg;

   typedef enum logic {
      RIB_STATE_IDLE = 1'b0,
      RIB_STATE_BUSY = 1'b1
   } rib_state_e;

   localparam int RIB_TMR_MIN_W = 8;

   // Timeout counter is never narrower than 8 bits, wider if TIMEOUT needs it.
   function automatic int rib_tmr_w(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      return (w > RIB_TMR_MIN_W) ? w : RIB_TMR_MIN_W;
   endfunction

endpackage

// File: rtl/rib_rr_arbiter.sv
// Round-robin pick: first requester at or after rr_ptr, wrapping; one-hot and binary grant.
// Purely combinational, zero latency; no backpressure of its own.
module rib_rr_arbiter
   import rib_rr_bus_pkg::*;
#(
   parameter int NUM_M = 4,
   parameter int PTR_W = 2
) (
   input  logic [NUM_M-1:0] req,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [NUM_M-1:0] grant_onehot,
   output logic [PTR_W-1:0] grant_bin,
   output logic             grant_vld
);

   always_comb begin
      int idx;
      grant_onehot = '0;
      grant_bin    = '0;
      grant_vld    = 1'b0;
      idx          = 0;
      for (int i = 0; i < NUM_M; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_M;
         if (!grant_vld && req[idx]) begin
            grant_vld         = 1'b1;
            grant_onehot[idx] = 1'b1;
            grant_bin         = PTR_W'(idx);
         end
      end
   end

endmodule

// File: rtl/rib_rr_bus.sv
// N-master / N-slave RIB bus: round-robin grant, address-MSB slave decode, req/ack handshake.
// Latency: ack no earlier than the cycle after req; slow slaves stall the bus by withholding ack.
// Optional RIB_TIMEOUT_EN forces completion (data 0) after TIMEOUT BUSY cycles without ack.
module rib_rr_bus
   import rib_rr_bus_pkg::*;
#(
   parameter int             NUM_M     = 4,
   parameter int             NUM_S     = 8,
   parameter int             AW        = 32,
   parameter int             DW        = 32,
   parameter int             SEL_W     = 4,
   parameter logic [NUM_M-1:0] HOLD_MASK = 4'hD,
   parameter int             TIMEOUT   = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_M*AW-1:0]   m_addr_i,
   input  logic [NUM_M*DW-1:0]   m_data_i,
   input  logic [NUM_M-1:0]      m_we_i,
   input  logic [NUM_M-1:0]      m_req_i,
   output logic [NUM_M*DW-1:0]   m_data_o,
   output logic [NUM_M-1:0]      m_ack_o,
   output logic [NUM_S*AW-1:0]   s_addr_o,
   output logic [NUM_S*DW-1:0]   s_data_o,
   output logic [NUM_S-1:0]      s_we_o,
   output logic [NUM_S-1:0]      s_req_o,
   input  logic [NUM_S*DW-1:0]   s_data_i,
   input  logic [NUM_S-1:0]      s_ack_i,
   output logic                  hold_flag_o
);

   localparam int PTR_W = $clog2(NUM_M);
   localparam int SW    = (NUM_S > 1) ? $clog2(NUM_S) : 1;

   rib_state_e       state_q, state_d;
   logic [PTR_W-1:0] grant_q, rr_ptr_q, arb_bin;
   logic [NUM_M-1:0] grant_oh_q, arb_onehot;
   logic             arb_vld;
   logic             busy, hit, done, timeout_hit;
   logic [AW-1:0]    g_addr;
   logic [DW-1:0]    g_data, rd_data;
   logic             g_we;
   logic [SEL_W-1:0] sel;
   logic [SW-1:0]    slv_idx;

   rib_rr_arbiter #(
      .NUM_M (NUM_M),
      .PTR_W (PTR_W)
   ) u_arb (
      .req          (m_req_i),
      .rr_ptr       (rr_ptr_q),
      .grant_onehot (arb_onehot),
      .grant_bin    (arb_bin),
      .grant_vld    (arb_vld)
   );

   assign busy    = (state_q == RIB_STATE_BUSY);
   assign g_addr  = m_addr_i[grant_q*AW +: AW];
   assign g_data  = m_data_i[grant_q*DW +: DW];
   assign g_we    = m_we_i[grant_q];
   assign sel     = g_addr[AW-1 -: SEL_W];
   assign slv_idx = sel[SW-1:0];
   assign hit     = busy && (int'(sel) < NUM_S);

   // A decode miss completes on its first BUSY cycle; s_ack_i of other lanes is never looked at.
   assign done    = busy && (!hit || s_ack_i[slv_idx] || timeout_hit);
   assign rd_data = (hit && s_ack_i[slv_idx]) ? s_data_i[slv_idx*DW +: DW] : '0;

   always_comb begin
      s_req_o  = '0;
      s_we_o   = '0;
      s_addr_o = '0;
      s_data_o = '0;
      m_ack_o  = '0;
      m_data_o = '0;
      if (hit) begin
         s_req_o[slv_idx]              = 1'b1;
         s_we_o[slv_idx]               = g_we;
         s_addr_o[slv_idx*AW +: AW]    = {{SEL_W{1'b0}}, g_addr[AW-SEL_W-1:0]};
         s_data_o[slv_idx*DW +: DW]    = g_data;
      end
      if (done) begin
         m_ack_o                       = grant_oh_q;
         m_data_o[grant_q*DW +: DW]    = rd_data;
      end
   end

   // Gated by reset so the core sees no hold while the bus is held in reset.
   assign hold_flag_o = rst && ((|(m_req_i & HOLD_MASK)) || (busy && HOLD_MASK[grant_q]));

   always_comb begin
      state_d = state_q;
      case (state_q)
         RIB_STATE_IDLE: if (arb_vld) state_d = RIB_STATE_BUSY;
         RIB_STATE_BUSY: if (done)    state_d = RIB_STATE_IDLE;
         default:                     state_d = RIB_STATE_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RIB_STATE_IDLE;
         grant_q    <= '0;
         grant_oh_q <= '0;
         rr_ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         if (!busy && arb_vld) begin
            grant_q    <= arb_bin;
            grant_oh_q <= arb_onehot;
         end
         if (done)
            rr_ptr_q <= (grant_q == PTR_W'(NUM_M-1)) ? '0 : grant_q + 1'b1;
      end
   end

`ifdef RIB_TIMEOUT_EN
   localparam int TMR_W = rib_tmr_w(TIMEOUT);
   logic [TMR_W-1:0] tmr_q;

   assign timeout_hit = busy && (tmr_q == TMR_W'(TIMEOUT-1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         tmr_q <= '0;
      else if (!busy || done)
         tmr_q <= '0;
      else
         tmr_q <= tmr_q + 1'b1;
   end
`else
   logic timeout_unused;
   assign timeout_hit    = 1'b0;
   assign timeout_unused = (TIMEOUT > 0);
`endif

endmodule

// File: tb/tb_rib_rr_bus.sv
// Bench for rib_rr_bus: directed scenarios with literal expectations plus random traffic,
// every cycle compared against a transaction-level model of the bus.
module tb_rib_rr_bus;

   localparam int NM = 4;
   localparam int NS = 8;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 64;
   localparam logic [NM-1:0] HOLD = 4'hD;

   logic              clk;
   logic              rst;
   logic [NM*AW-1:0]  m_addr_i;
   logic [NM*DW-1:0]  m_data_i;
   logic [NM-1:0]     m_we_i;
   logic [NM-1:0]     m_req_i;
   logic [NM*DW-1:0]  m_data_o;
   logic [NM-1:0]     m_ack_o;
   logic [NS*AW-1:0]  s_addr_o;
   logic [NS*DW-1:0]  s_data_o;
   logic [NS-1:0]     s_we_o;
   logic [NS-1:0]     s_req_o;
   logic [NS*DW-1:0]  s_data_i;
   logic [NS-1:0]     s_ack_i;
   logic              hold_flag_o;

   int n_pass = 0;
   int n_chk  = 0;

   // model: one outstanding transaction at most
   bit        mb;
   int        mg, mr, mt;
   logic [NM-1:0] last_ack;

   rib_rr_bus u_dut (
      .clk         (clk),
      .rst         (rst),
      .m_addr_i    (m_addr_i),
      .m_data_i    (m_data_i),
      .m_we_i      (m_we_i),
      .m_req_i     (m_req_i),
      .m_data_o    (m_data_o),
      .m_ack_o     (m_ack_o),
      .s_addr_o    (s_addr_o),
      .s_data_o    (s_data_o),
      .s_we_o      (s_we_o),
      .s_req_o     (s_req_o),
      .s_data_i    (s_data_i),
      .s_ack_i     (s_ack_i),
      .hold_flag_o (hold_flag_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   task automatic model_check();
      logic [NM-1:0]    e_ack;
      logic [NM*DW-1:0] e_mdata;
      logic [NS-1:0]    e_sreq, e_swe;
      logic [NS*AW-1:0] e_saddr;
      logic [NS*DW-1:0] e_sdata;
      logic             e_hold;
      logic             fin;
      bit               found;
      int               sel, k;
      e_ack = '0; e_mdata = '0; e_sreq = '0; e_swe = '0;
      e_saddr = '0; e_sdata = '0; fin = 1'b0; sel = 0; found = 0;
      if (rst && mb) begin
         sel = int'(m_addr_i[mg*AW+28 +: 4]);
         if (sel >= NS) fin = 1'b1;
         else begin
            e_sreq[sel] = 1'b1;
            e_swe[sel]  = m_we_i[mg];
            e_saddr[sel*AW +: AW] = m_addr_i[mg*AW +: AW] & 32'h0FFF_FFFF;
            e_sdata[sel*DW +: DW] = m_data_i[mg*DW +: DW];
            if (s_ack_i[sel]) begin
               fin = 1'b1;
               e_mdata[mg*DW +: DW] = s_data_i[sel*DW +: DW];
            end
         end
`ifdef RIB_TIMEOUT_EN
         if (mt == TO-1) fin = 1'b1;
`endif
         if (fin) e_ack[mg] = 1'b1;
      end
      e_hold = rst && (((m_req_i & HOLD) != 0) || (mb && HOLD[mg]));
      chk("m_ack_o",     m_ack_o,     e_ack);
      chk("m_data_o",    m_data_o,    e_mdata);
      chk("s_req_o",     s_req_o,     e_sreq);
      chk("s_we_o",      s_we_o,      e_swe);
      chk("s_addr_o",    s_addr_o,    e_saddr);
      chk("s_data_o",    s_data_o,    e_sdata);
      chk("hold_flag_o", hold_flag_o, e_hold);
      last_ack = e_ack;
      if (!rst) begin
         mb = 0; mr = 0; mt = 0; mg = 0;
      end else if (!mb) begin
         for (int j = 0; j < NM; j++) begin
            k = (mr + j) % NM;
            if (!found && m_req_i[k]) begin
               found = 1; mb = 1; mg = k; mt = 0;
            end
         end
      end else if (fin) begin
         mb = 0; mr = (mg + 1) % NM;
      end else begin
         mt++;
      end
   endtask

   // Called with inputs already set (at a falling edge); returns at the next falling edge.
   task automatic cyc();
      #2;
      model_check();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      m_req_i = '0; m_we_i = '0; m_addr_i = '0; m_data_i = '0;
      s_ack_i = '0; s_data_i = '0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      idle_inputs();
      cyc();
      cyc();
      rst = 1'b1;
   endtask

   task automatic rand_slaves();
      s_ack_i = 8'($urandom) & 8'($urandom);
      for (int s = 0; s < NS; s++) s_data_i[s*DW +: DW] = $urandom;
   endtask

   initial begin
      logic [3:0] nib;
      bit         pending [NM];
      int         acks [$];
      int         we_cnt, ack_cnt, to_cyc;

      mb = 0; mg = 0; mr = 0; mt = 0; last_ack = '0;
      rst = 1'b0;
      idle_inputs();
      @(negedge clk);

      // 1: reset with random inputs, then idle after release
      m_req_i = 4'($urandom) | 4'h1;
      m_we_i  = 4'($urandom);
      for (int k = 0; k < NM; k++) begin
         m_addr_i[k*AW +: AW] = $urandom;
         m_data_i[k*DW +: DW] = $urandom;
      end
      rand_slaves();
      #1;
      chk("rst_m_ack",  m_ack_o,  '0);
      chk("rst_s_req",  s_req_o,  '0);
      chk("rst_s_addr", s_addr_o, '0);
      chk("rst_hold",   hold_flag_o, 1'b0);
      cyc();
      idle_inputs();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("idle_s_req", s_req_o, '0);
         cyc();
      end

      // 2: M0 read 0x1000_0004, slave1 acks on first BUSY cycle
      do_reset();
      m_req_i[0] = 1'b1;
      m_addr_i[31:0] = 32'h1000_0004;
      #1 chk("t2_c0_ack", m_ack_o, 4'b0000);
      cyc();
      s_ack_i[1] = 1'b1;
      s_data_i[63:32] = 32'hDEAD_BEEF;
      #1;
      chk("t2_s_addr1", s_addr_o[63:32], 32'h0000_0004);
      chk("t2_ack",     m_ack_o,         4'b0001);
      chk("t2_data",    m_data_o[31:0],  32'hDEAD_BEEF);
      cyc();
      idle_inputs();
      cyc();

      // 3: all masters request continuously -> 0,1,2,3,0
      do_reset();
      m_req_i = 4'hF;
      for (int k = 0; k < NM; k++) m_addr_i[k*AW +: AW] = 32'(k * 4);
      s_ack_i = '1;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("t3_hold", hold_flag_o, 1'b1);
         for (int k = 0; k < NM; k++) if (m_ack_o[k]) acks.push_back(k);
         cyc();
      end
      chk("t3_nacks", 32'(acks.size()), 32'd5);
      if (acks.size() == 5) begin
         chk("t3_g0", 32'(acks[0]), 32'd0);
         chk("t3_g1", 32'(acks[1]), 32'd1);
         chk("t3_g2", 32'(acks[2]), 32'd2);
         chk("t3_g3", 32'(acks[3]), 32'd3);
         chk("t3_g4", 32'(acks[4]), 32'd0);
      end
      idle_inputs();
      cyc();

      // 4: M2 write 0x2000_0010 data 0x55, slave2 waits 5 cycles
      do_reset();
      m_addr_i[2*AW +: AW] = 32'h2000_0010;
      m_data_i[2*DW +: DW] = 32'h55;
      m_we_i[2] = 1'b1;
      we_cnt = 0; ack_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         m_req_i[2] = (i <= 6);
         s_ack_i[2] = (i == 6);
         #1;
         if (s_we_o[2]) we_cnt++;
         if (m_ack_o[2]) ack_cnt++;
         if (i == 1) chk("t4_s_data2", s_data_o[2*DW +: DW], 32'h55);
         cyc();
      end
      chk("t4_we_cycles", 32'(we_cnt), 32'd6);
      chk("t4_ack_pulses", 32'(ack_cnt), 32'd1);
      idle_inputs();

      // 5: decode miss from M3, slave acks everywhere must be ignored
      m_req_i[3] = 1'b1;
      m_addr_i[3*AW +: AW] = 32'h9000_0000;
      cyc();
      rand_slaves();
      s_ack_i = '1;
      #1;
      chk("t5_s_req",  s_req_o,           '0);
      chk("t5_ack",    m_ack_o,           4'b1000);
      chk("t5_data",   m_data_o[127:96],  32'h0);
      cyc();
      idle_inputs();
      cyc();

`ifdef RIB_TIMEOUT_EN
      // 6: slave3 never acks -> forced completion on 64th BUSY cycle
      do_reset();
      m_req_i[0] = 1'b1;
      m_addr_i[31:0] = 32'h3000_0000;
      to_cyc = -1;
      for (int i = 0; i < 80; i++) begin
         #1;
         if (m_ack_o[0] && to_cyc < 0) begin
            to_cyc = i;
            chk("t6_data", m_data_o[31:0], 32'h0);
         end
         if (i == 64) m_req_i[0] = 1'b0;
         cyc();
      end
      chk("t6_ack_cycle", 32'(to_cyc), 32'd64);
      idle_inputs();
`else
      to_cyc = 0;
`endif

      // random traffic
      do_reset();
      for (int k = 0; k < NM; k++) pending[k] = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < NM; k++) begin
            if (last_ack[k]) begin
               pending[k] = 0;
               m_req_i[k] = 1'b0;
            end else if (pending[k] && mb && mg == k && ($urandom % 8) == 0) begin
               m_req_i[k] = 1'b0;
            end
            if (!pending[k] && ($urandom % 3) == 0) begin
               nib = 4'($urandom_range(0, 9));
               pending[k] = 1;
               m_req_i[k] = 1'b1;
               m_addr_i[k*AW +: AW] = {nib, 28'($urandom)};
               m_data_i[k*DW +: DW] = $urandom;
               m_we_i[k] = 1'($urandom);
            end
         end
         rand_slaves();
         cyc();
      end

      // reset in the middle of a stalled transaction
      do_reset();
      m_req_i[1] = 1'b1;
      m_addr_i[1*AW +: AW] = 32'h3000_0040;
      cyc();
      cyc();
      cyc();
      #1;
      rst = 1'b0;
      #1;
      chk("rstbusy_m_ack", m_ack_o,     '0);
      chk("rstbusy_s_req", s_req_o,     '0);
      chk("rstbusy_s_we",  s_we_o,      '0);
      chk("rstbusy_hold",  hold_flag_o, 1'b0);
      cyc();
      idle_inputs();
      rst = 1'b1;
      cyc();
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
